dm_arbiter: RTL



---
 rtl/dm_arbiter_pkg.sv | 19 +
 rtl/dm_lane_unit.sv | 57 +++++
 rtl/dm_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared size codes, state encoding and memory size for the data-memory arbiter
package dm_arbiter_pkg;

  // Access size codes as presented on cpu_size / dbg_size
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RMW    = 2'd2
  } state_t;

  // Data memory size in bytes
  localparam int RAM_MAX = 1024;

endpackage

// File: rtl/dm_lane_unit.sv
// rtl/dm_lane_unit.sv - combinational byte/half lane extract, store merge and alignment check
//
// Ports:
//   size      access size code (SIZE_B/H/W/RSV)
//   sign      loads: 1 = sign-extend, 0 = zero-extend
//   addr_lo   low two bits of the byte address
//   wdata     right-aligned store data
//   word      memory word the access targets
//   load_data extracted and extended load result
//   merged    word with the addressed lane replaced by store data
//   err       reserved size or misaligned half/word
module dm_lane_unit
  import dm_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [31:0] load_data,
  output logic [31:0] merged,
  output logic        err
);

  logic [4:0]  bit_off;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    bit_off   = {addr_lo, 3'b000};
    lane_b    = word[bit_off +: 8];
    lane_h    = addr_lo[1] ? word[31:16] : word[15:0];
    load_data = '0;
    merged    = word;
    err       = 1'b0;
    case (size)
      SIZE_B: begin
        load_data = {{24{sign & lane_b[7]}}, lane_b};
        merged[bit_off +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        err       = addr_lo[0];
        load_data = {{16{sign & lane_h[15]}}, lane_h};
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      SIZE_W: begin
        err       = (addr_lo != 2'b00);
        load_data = word;
        merged    = wdata;
      end
      SIZE_RSV: err = 1'b1;
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - arbitrates cpu and debug ports onto a word-only data memory, sequencing sub-word accesses
//
// Optional trace: define DM_ARB_TRACE_EN to print every memory write as
//   "@<pc>: *<word address> <= <merged word>".
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   cpu_req..cpu_pc     CPU request and fields, held stable until cpu_gnt
//   cpu_gnt             one-cycle pulse when the request is latched
//   cpu_done/err/rdata  one-cycle completion pulse, error flag and load data
//   dbg_*               debug/loader port, same semantics, traced with PC 0
//   mem_addr/we/wdata   word-aligned address, write enable and data to memory
//   mem_rdata           combinational read of the word at mem_addr
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DBG_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sign,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [31:0]       cpu_pc,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic              dbg_sign,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic              dbg_err,
  output logic [31:0]       dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state_q;
  logic              owner_dbg_q;
  logic              last_tie_dbg_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       pc_q;
  logic [31:0]       old_q;

  logic              pick_dbg;
  logic [31:0]       lane_word;
  logic [31:0]       lane_load;
  logic [31:0]       lane_merged;
  logic              lane_err;
  logic              fin;
  logic              fin_err;
  logic [31:0]       fin_rdata;

  // Ties go to the loser of the previous tie unless dbg has fixed priority
  always_comb begin
    pick_dbg = dbg_req & ~cpu_req;
    if (cpu_req && dbg_req)
      pick_dbg = (DBG_PRIORITY != 0) || !last_tie_dbg_q;
  end

  // In RMW the merge must use the word captured during ACCESS
  assign lane_word = (state_q == ST_RMW) ? old_q : mem_rdata;

  dm_lane_unit u_lane (
    .size      (size_q),
    .sign      (sign_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .word      (lane_word),
    .load_data (lane_load),
    .merged    (lane_merged),
    .err       (lane_err)
  );

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = lane_merged;
  // Gated by reset so an aborted RMW never reaches memory
  assign mem_we    = !reset &&
                     (((state_q == ST_ACCESS) && we_q && (size_q == SIZE_W) && !lane_err) ||
                      (state_q == ST_RMW));

  // Completion of the current access, reported on the next edge
  always_comb begin
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    case (state_q)
      ST_ACCESS: begin
        if (lane_err) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (!(we_q && (size_q != SIZE_W))) begin
          fin = 1'b1;
          if (!we_q) fin_rdata = lane_load;
        end
      end
      ST_RMW:  fin = 1'b1;
      default: fin = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_dbg_q    <= 1'b0;
      last_tie_dbg_q <= 1'b1;
      we_q           <= 1'b0;
      size_q         <= SIZE_B;
      sign_q         <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      pc_q           <= '0;
      old_q          <= '0;
      cpu_gnt        <= 1'b0;
      cpu_done       <= 1'b0;
      cpu_err        <= 1'b0;
      cpu_rdata      <= '0;
      dbg_gnt        <= 1'b0;
      dbg_done       <= 1'b0;
      dbg_err        <= 1'b0;
      dbg_rdata      <= '0;
    end else begin
      cpu_gnt  <= 1'b0;
      dbg_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      cpu_err  <= 1'b0;
      dbg_err  <= 1'b0;

      if (fin) begin
        if (owner_dbg_q) begin
          dbg_done  <= 1'b1;
          dbg_err   <= fin_err;
          dbg_rdata <= fin_rdata;
        end else begin
          cpu_done  <= 1'b1;
          cpu_err   <= fin_err;
          cpu_rdata <= fin_rdata;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (cpu_req || dbg_req) begin
            state_q     <= ST_ACCESS;
            owner_dbg_q <= pick_dbg;
            cpu_gnt     <= !pick_dbg;
            dbg_gnt     <= pick_dbg;
            if (cpu_req && dbg_req) last_tie_dbg_q <= pick_dbg;
            we_q    <= pick_dbg ? dbg_we    : cpu_we;
            size_q  <= pick_dbg ? dbg_size  : cpu_size;
            sign_q  <= pick_dbg ? dbg_sign  : cpu_sign;
            addr_q  <= pick_dbg ? dbg_addr  : cpu_addr;
            wdata_q <= pick_dbg ? dbg_wdata : cpu_wdata;
            pc_q    <= pick_dbg ? 32'h0     : cpu_pc;
          end
        end
        ST_ACCESS: begin
          if (!lane_err && we_q && (size_q != SIZE_W)) begin
            old_q   <= mem_rdata;
            state_q <= ST_RMW;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RMW:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DM_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      $display("@%h: *%h <= %h", pc_q, mem_addr, mem_wdata);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule
